soc_boot_ctrl: RTL and testbench
================================

// Module: soc_boot_ctrl
// PURPOSE
//  Run controller sitting directly upstream of the SoC. Streams a program image from a host
//  word interface into SoC memory, holds the CPU in reset during load, then pulses start,
//  waits for finish (0 then 1) and reports cycle count, done or timeout.
//  Hardware equivalent of the bench load/reset/start/wait_finish sequence.
// PARAMETERS
//  AW          9      memory word-address width
//  BASE_ADDR   0      first address written by the load
//  RST_CYCLES  3      cycles cpu_rst_b is held low after load (>=1)
//  MAX_CYCLES  10000  run timeout in clk cycles, counted from the start pulse
//  CNT_W       16     cycle-counter width (2^CNT_W > MAX_CYCLES)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_b       in   1      asynchronous active-low reset
//  go          in   1      begin load+run; sampled only in IDLE/DONE/TIMEOUT/ERROR
//  ld_valid    in   1      host word valid
//  ld_data     in   16     program word
//  ld_last     in   1      marks final word of image
//  ld_ready    out  1      controller accepts word (valid&ready = transfer)
//  mem_addr    out  AW     memory write address
//  mem_din     out  16     memory write data
//  mem_wr      out  1      memory write strobe, one cycle per word
//  cpu_rst_b   out  1      active-low CPU reset driven into SoC
//  cpu_start   out  1      one-cycle start pulse to SoC
//  cpu_finish  in   1      SoC finish (1 idle/halted, 0 running)
//  busy        out  1      1 in any state except IDLE/DONE/TIMEOUT/ERROR
//  done        out  1      run completed normally (sticky until next go)
//  timeout     out  1      run exceeded MAX_CYCLES (sticky until next go)
//  error       out  1      image overflowed 2^AW words (sticky until next go)
//  cycles      out  CNT_W  cycles from start pulse to finish rising; frozen after end
// BEHAVIOUR
//  Reset (rst_b=0, async): state IDLE, ld_ready=0, mem_wr=0, mem_addr=BASE_ADDR, mem_din=0,
//   cpu_rst_b=0, cpu_start=0, busy/done/timeout/error=0, cycles=0.
//   rst_b falling mid-operation aborts immediately; no partial write completes afterwards.
//  FSM: IDLE -> LOAD -> CPURST -> START -> WAITLO -> RUN -> DONE | TIMEOUT; LOAD -> ERROR.
//  IDLE/DONE/TIMEOUT/ERROR: go=1 -> LOAD next edge; clears done/timeout/error/cycles;
//   mem_addr<=BASE_ADDR; cpu_rst_b<=0.
//  LOAD: ld_ready=1 (registered, asserted the cycle after entry); on valid&ready, the next
//   edge registers mem_din<=ld_data, mem_addr<=current ptr, mem_wr<=1 (1-cycle write latency);
//   ptr increments. Back-to-back words sustain 1 word/cycle. ld_valid=0 -> no write, ptr held.
//   ld_last on a transfer -> CPURST, ld_ready drops the following cycle.
//   A transfer with ptr = BASE_ADDR+2^AW-1 and ld_last=0 -> write done, then ERROR;
//   no wrap, cpu_rst_b stays 0.
//  CPURST: cpu_rst_b=0 for exactly RST_CYCLES cycles after the last mem_wr, then cpu_rst_b=1
//   -> START.
//  START: cpu_start=1 for exactly one cycle; cycles reset to 0 and counts from here.
//  WAITLO: wait for cpu_finish=0; cycles increments each clk.
//  RUN: cpu_finish=1 -> DONE (done=1, cycles frozen); finish high during WAITLO is ignored.
//  cycles >= MAX_CYCLES in WAITLO/RUN -> TIMEOUT (timeout=1, cpu_rst_b<=0 to stop CPU).
//   finish and limit on same edge: DONE wins.
//  cycles saturates at all-ones, never wraps. go while busy is ignored.
//  cpu_rst_b stays 1 in DONE, preserving CPU state for inspection.
// TESTING
//  T1 reset: rst_b=0 3 cycles -> all outputs at reset values, cpu_rst_b=0, ld_ready=0.
//  T2 load 4 words A001,A002,A003,A004 (last on 4th), no gaps -> mem_wr 4 consecutive cycles,
//   addr 000..003, then cpu_rst_b=0 for 3 cycles, one start pulse.
//  T3 load with ld_valid gaps (1,0,0,1,1) -> only 3 writes, addresses contiguous 000..002.
//  T4 SoC model drops finish 1 cycle after start, raises it 20 cycles later -> done=1,
//   cycles=22, busy=0, cpu_rst_b=1.
//  T5 MAX_CYCLES=50, finish never returns -> timeout=1 at cycles=50, cpu_rst_b=0;
//   go restarts cleanly.
//  T6 513 words with AW=9, no ld_last -> 512 writes, error=1, no start pulse;
//   rst_b pulsed mid-LOAD -> IDLE, mem_wr=0.

Source files
------------

// File: rtl/soc_boot_ctrl.sv
// Boot/run controller: streams a host image into SoC memory, holds the CPU in reset,
// pulses start, then times the run until finish rises or the cycle limit expires.
module soc_boot_ctrl #(
  parameter int AW         = 9,
  parameter int BASE_ADDR  = 0,
  parameter int RST_CYCLES = 3,
  parameter int MAX_CYCLES = 10000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             go,
  input  logic             ld_valid,
  input  logic [15:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic [AW-1:0]    mem_addr,
  output logic [15:0]      mem_din,
  output logic             mem_wr,
  output logic             cpu_rst_b,
  output logic             cpu_start,
  input  logic             cpu_finish,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             error,
  output logic [CNT_W-1:0] cycles,
  output logic [3:0]       dbg_state
);

  localparam int                RW       = $clog2(RST_CYCLES + 1);
  localparam logic [AW-1:0]     BASE     = AW'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(MAX_CYCLES);
  localparam logic [RW-1:0]     RST_LAST = RW'(RST_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CPURST, S_START, S_WAITLO, S_RUN, S_DONE, S_TIMEOUT, S_ERROR
  } state_t;

  // Handshake: a word moves on any rising edge where ld_valid and ld_ready are both 1;
  // the host holds ld_data/ld_last stable while ld_valid is high and ld_ready is low.
  state_t          state;
  state_t          next_state;
  logic [AW-1:0]   idx;
  logic [RW-1:0]   rcnt;
  logic            xfer;
  logic            at_limit;

  assign xfer      = ld_valid & ld_ready;
  assign at_limit  = (cycles >= LIMIT);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT, S_ERROR: if (go) next_state = S_LOAD;
      S_LOAD: begin
        if (xfer) begin
          if (ld_last)                  next_state = S_CPURST;
          else if (idx == {AW{1'b1}})   next_state = S_ERROR;
        end
      end
      S_CPURST: if (rcnt == RST_LAST) next_state = S_START;
      S_START:  next_state = S_WAITLO;
      // finish still high here is the CPU not yet running; only a 0 arms RUN
      S_WAITLO: begin
        if (at_limit)         next_state = S_TIMEOUT;
        else if (!cpu_finish) next_state = S_RUN;
      end
      S_RUN: begin
        if (cpu_finish)       next_state = S_DONE;
        else if (at_limit)    next_state = S_TIMEOUT;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready  = 1'b0;
    cpu_start = 1'b0;
    cpu_rst_b = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    timeout   = 1'b0;
    error     = 1'b0;
    case (state)
      S_IDLE:           busy = 1'b0;
      S_LOAD:           ld_ready = 1'b1;
      S_START: begin
        cpu_start = 1'b1;
        cpu_rst_b = 1'b1;
      end
      S_WAITLO, S_RUN:  cpu_rst_b = 1'b1;
      // CPU left out of reset so its state can be inspected after the run
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        cpu_rst_b = 1'b1;
      end
      S_TIMEOUT: begin
        busy    = 1'b0;
        timeout = 1'b1;
      end
      S_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_addr <= BASE;
      mem_din  <= '0;
      mem_wr   <= 1'b0;
      idx      <= '0;
      rcnt     <= '0;
      cycles   <= '0;
    end else begin
      mem_wr <= 1'b0;
      if (!busy && go) begin
        idx      <= '0;
        mem_addr <= BASE;
        cycles   <= '0;
      end
      if (xfer) begin
        mem_addr <= BASE + idx;
        mem_din  <= ld_data;
        mem_wr   <= 1'b1;
        idx      <= idx + 1'b1;
      end
      rcnt <= (state == S_CPURST) ? rcnt + 1'b1 : '0;
      // counts every edge from the start cycle up to and including the DONE edge;
      // the edge into TIMEOUT leaves it at the limit
      if (state == S_START ||
          ((state == S_WAITLO || state == S_RUN) && next_state != S_TIMEOUT)) begin
        if (cycles != {CNT_W{1'b1}}) cycles <= cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// Bench for soc_boot_ctrl: vector table for the first load/run, randomized load+run
// transactions against an arithmetic run model, then overflow and mid-load reset.
module tb_soc_boot_ctrl;
  localparam int AW    = 9;
  localparam int BASE  = 0;
  localparam int RSTC  = 3;
  localparam int MAXC  = 50;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             go = 1'b0;
  logic             ld_valid = 1'b0;
  logic [15:0]      ld_data = '0;
  logic             ld_last = 1'b0;
  logic             cpu_finish = 1'b1;
  logic             ld_ready, mem_wr, cpu_rst_b, cpu_start, busy, done, timeout, error;
  logic [AW-1:0]    mem_addr;
  logic [15:0]      mem_din;
  logic [CNT_W-1:0] cycles;
  logic [3:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr     = 0;
  int n_start  = 0;
  int cyc      = 0;
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] mon_e;

  soc_boot_ctrl #(
    .AW(AW), .BASE_ADDR(BASE), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_b(rst_b), .go(go), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wr(mem_wr), .cpu_rst_b(cpu_rst_b), .cpu_start(cpu_start),
    .cpu_finish(cpu_finish), .busy(busy), .done(done), .timeout(timeout),
    .error(error), .cycles(cycles), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: each mem_wr cycle must match the oldest expected {addr,data}
  initial forever begin
    @(negedge clk);
    if (cpu_start) n_start++;
    if (mem_wr) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_extra: got write addr %0h data %0h expected none", mem_addr, mem_din);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e[AW+15:16]));
        check("wr_data", 32'(mem_din), 32'(mon_e[15:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] dat, input logic last, input int gap);
    logic ok;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    repeat (gap) tick();
    ld_valid = 1'b1;
    ld_data  = dat;
    ld_last  = last;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      ok = ld_ready;
      tick();
    end
    check("ld_accept", 32'(ok), 32'd1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // full transaction: go, load nw words, SoC drops finish d cycles after start and
  // raises it h cycles later (h<0: never)
  task automatic do_run(input int nw, input int maxgap, input int d, input int h,
                        input bit b2b, input bit seqd);
    int w0, s0, c0, lowc, exp_cyc;
    logic [15:0] dat;
    logic exp_done;
    w0 = n_wr;
    s0 = n_start;
    cpu_finish = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_busy", 32'(busy), 32'd1);
    check("go_clear_done", 32'(done | timeout | error), 32'd0);
    c0 = cyc;
    for (int i = 0; i < nw; i++) begin
      dat = seqd ? 16'(16'hA001 + i) : 16'($urandom);
      exp_q.push_back({AW'(BASE + i), dat});
      send_word(dat, (i == nw - 1), b2b ? 0 : $urandom_range(0, maxgap));
    end
    if (b2b) check("b2b_rate", 32'(cyc - c0), 32'(nw));
    lowc = 0;
    for (int t = 0; t < 100 && cpu_rst_b == 1'b0; t++) begin
      tick();
      if (cpu_rst_b == 1'b0) lowc++;
    end
    check("rst_hold", 32'(lowc), 32'(RSTC));
    check("start_pulse", 32'(cpu_start), 32'd1);
    check("load_writes", 32'(n_wr - w0), 32'(nw));
    repeat (d) tick();
    cpu_finish = 1'b0;
    if (h >= 0) begin
      repeat (h) tick();
      cpu_finish = 1'b1;
    end
    for (int t = 0; t < MAXC + 20 && busy; t++) tick();
    exp_done = (h >= 0) && (d + h <= MAXC);
    exp_cyc  = exp_done ? d + h + 1 : MAXC;
    check("run_busy", 32'(busy), 32'd0);
    check("run_done", 32'(done), 32'(exp_done));
    check("run_timeout", 32'(timeout), 32'(!exp_done));
    check("run_cycles", 32'(cycles), 32'(exp_cyc));
    check("run_cpu_rst_b", 32'(cpu_rst_b), 32'(exp_done));
    check("run_error", 32'(error), 32'd0);
    check("run_starts", 32'(n_start - s0), 32'd1);
    cpu_finish = 1'b1;
  endtask

  typedef struct {
    logic go, vld; logic [15:0] data; logic last, fin;
    logic busy, rdy, wr; logic [AW-1:0] addr; logic [15:0] din;
    logic rstb, start, done; logic [CNT_W-1:0] cyc;
  } vec_t;
  vec_t vecs[14];

  initial begin
    int w0, s0, acc, nw, d, h;
    //             go vld data      lst fin | busy rdy wr addr din       rstb st dn cyc
    vecs[0]  = '{0, 1, 16'h5555, 0, 1,   0, 0, 0, 9'd0, 16'h0000, 0, 0, 0, 16'd0};
    vecs[1]  = '{1, 0, 16'h0000, 0, 1,   1, 1, 0, 9'd0, 16'h0000, 0, 0, 0, 16'd0};
    vecs[2]  = '{0, 1, 16'h1234, 0, 1,   1, 1, 1, 9'd0, 16'h1234, 0, 0, 0, 16'd0};
    vecs[3]  = '{0, 0, 16'h7777, 0, 1,   1, 1, 0, 9'd0, 16'h1234, 0, 0, 0, 16'd0};
    vecs[4]  = '{0, 1, 16'hBEEF, 1, 1,   1, 0, 1, 9'd1, 16'hBEEF, 0, 0, 0, 16'd0};
    vecs[5]  = '{1, 0, 16'h0000, 0, 1,   1, 0, 0, 9'd1, 16'hBEEF, 0, 0, 0, 16'd0};
    vecs[6]  = '{0, 0, 16'h0000, 0, 1,   1, 0, 0, 9'd1, 16'hBEEF, 0, 0, 0, 16'd0};
    vecs[7]  = '{0, 0, 16'h0000, 0, 1,   1, 0, 0, 9'd1, 16'hBEEF, 0, 0, 0, 16'd0};
    vecs[8]  = '{0, 0, 16'h0000, 0, 1,   1, 0, 0, 9'd1, 16'hBEEF, 1, 1, 0, 16'd0};
    vecs[9]  = '{0, 0, 16'h0000, 0, 1,   1, 0, 0, 9'd1, 16'hBEEF, 1, 0, 0, 16'd1};
    vecs[10] = '{0, 0, 16'h0000, 0, 1,   1, 0, 0, 9'd1, 16'hBEEF, 1, 0, 0, 16'd2};
    vecs[11] = '{0, 0, 16'h0000, 0, 0,   1, 0, 0, 9'd1, 16'hBEEF, 1, 0, 0, 16'd3};
    vecs[12] = '{0, 0, 16'h0000, 0, 1,   0, 0, 0, 9'd1, 16'hBEEF, 1, 0, 1, 16'd4};
    vecs[13] = '{0, 0, 16'h0000, 0, 1,   0, 0, 0, 9'd1, 16'hBEEF, 1, 0, 1, 16'd4};

    // reset
    rst_b = 1'b0;
    repeat (3) tick();
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_cpu_rst_b", 32'(cpu_rst_b), 32'd0);
    check("rst_cpu_start", 32'(cpu_start), 32'd0);
    check("rst_flags", 32'({busy, done, timeout, error}), 32'd0);
    check("rst_cycles", 32'(cycles), 32'd0);
    rst_b = 1'b1;
    tick();

    // vector table: two-word load with a gap, then a short run
    exp_q.push_back({9'd0, 16'h1234});
    exp_q.push_back({9'd1, 16'hBEEF});
    for (int k = 0; k < 14; k++) begin
      go = vecs[k].go; ld_valid = vecs[k].vld; ld_data = vecs[k].data;
      ld_last = vecs[k].last; cpu_finish = vecs[k].fin;
      tick();
      check($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].busy));
      check($sformatf("v%0d_ld_ready", k), 32'(ld_ready), 32'(vecs[k].rdy));
      check($sformatf("v%0d_mem_wr", k), 32'(mem_wr), 32'(vecs[k].wr));
      check($sformatf("v%0d_mem_addr", k), 32'(mem_addr), 32'(vecs[k].addr));
      check($sformatf("v%0d_mem_din", k), 32'(mem_din), 32'(vecs[k].din));
      check($sformatf("v%0d_cpu_rst_b", k), 32'(cpu_rst_b), 32'(vecs[k].rstb));
      check($sformatf("v%0d_cpu_start", k), 32'(cpu_start), 32'(vecs[k].start));
      check($sformatf("v%0d_done", k), 32'(done), 32'(vecs[k].done));
      check($sformatf("v%0d_cycles", k), 32'(cycles), 32'(vecs[k].cyc));
    end
    go = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; cpu_finish = 1'b1;

    // hand-written corner runs
    do_run(4, 0, 1, 20, 1'b1, 1'b1);   // A001..A004 back to back, cycles=22
    do_run(3, 2, 1, 10, 1'b0, 1'b0);   // gapped load
    do_run(3, 1, 1, -1, 1'b0, 1'b0);   // finish never returns -> timeout at limit
    do_run(2, 0, 2, 48, 1'b1, 1'b0);   // finish rises on the limit edge: done wins
    do_run(1, 0, 1, 48, 1'b1, 1'b0);   // one below the limit
    for (int r = 0; r < 6; r++) begin
      nw = $urandom_range(1, 10);
      d  = $urandom_range(1, 4);
      h  = $urandom_range(1, 60);
      do_run(nw, 3, d, h, 1'b0, 1'b0);
    end

    // overflow: 513 words offered with no ld_last
    w0 = n_wr; s0 = n_start; acc = 0;
    go = 1'b1; tick(); go = 1'b0;
    for (int i = 0; i < 520; i++) begin
      ld_valid = 1'b1; ld_data = 16'($urandom); ld_last = 1'b0;
      if (ld_ready) begin
        exp_q.push_back({AW'(BASE + acc), ld_data});
        acc++;
      end
      tick();
      if (acc == 513) break;
    end
    ld_valid = 1'b0;
    repeat (2) tick();
    check("ovf_accepted", 32'(acc), 32'd512);
    check("ovf_writes", 32'(n_wr - w0), 32'd512);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    check("ovf_cpu_rst_b", 32'(cpu_rst_b), 32'd0);
    check("ovf_no_start", 32'(n_start - s0), 32'd0);
    check("ovf_last_addr", 32'(mem_addr), 32'((BASE + 511) % 512));

    // reset pulsed while a write is pending in LOAD
    go = 1'b1; tick(); go = 1'b0;
    check("err_restart_clear", 32'(error), 32'd0);
    w0 = n_wr;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({AW'(BASE + i), 16'(16'hC000 + i)});
      send_word(16'(16'hC000 + i), 1'b0, 0);
    end
    check("midrst_pending_wr", 32'(mem_wr), 32'd1);
    #1 rst_b = 1'b0;
    #1;
    check("midrst_mem_wr", 32'(mem_wr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'(BASE));
    exp_q.delete();
    tick();
    rst_b = 1'b1;
    repeat (3) tick();
    check("midrst_writes", 32'(n_wr - w0), 32'd2);
    check("midrst_idle", 32'({busy, done, timeout, error, cpu_rst_b}), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
